// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, 6-bit opcodes, flag bit positions and shifter modes.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [5:0] OP_ADD    = 6'h00;
    localparam logic [5:0] OP_SUB    = 6'h01;
    localparam logic [5:0] OP_AND    = 6'h02;
    localparam logic [5:0] OP_OR     = 6'h03;
    localparam logic [5:0] OP_XOR    = 6'h04;
    localparam logic [5:0] OP_NOT    = 6'h05;
    localparam logic [5:0] OP_ADC    = 6'h06;
    localparam logic [5:0] OP_SHL    = 6'h07;
    localparam logic [5:0] OP_SHR    = 6'h08;
    localparam logic [5:0] OP_ROL    = 6'h09;
    localparam logic [5:0] OP_ROR    = 6'h0A;
    localparam logic [5:0] OP_CMP    = 6'h0B;
    localparam logic [5:0] OP_INC    = 6'h0C;
    localparam logic [5:0] OP_DEC    = 6'h0D;
    localparam logic [5:0] OP_PASS_A = 6'h0E;
    localparam logic [5:0] OP_PASS_B = 6'h0F;
    localparam logic [5:0] OP_NAND   = 6'h10;
    localparam logic [5:0] OP_NOR    = 6'h11;
    localparam logic [5:0] OP_XNOR   = 6'h12;
    localparam logic [5:0] OP_CLR    = 6'h13;
    localparam logic [5:0] OP_SET    = 6'h14;
    localparam logic [5:0] OP_SBB    = 6'h15;

    localparam int unsigned NUM_FLAGS = 4;
    localparam int unsigned FLAG_V    = 0;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_S    = 2;
    localparam int unsigned FLAG_Z    = 3;

    typedef enum logic [1:0] {
        SH_SHL = 2'd0,
        SH_SHR = 2'd1,
        SH_ROL = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_e;

endpackage

// File: rtl/alu_32bit_unit_if.sv
// Operand/opcode bus into the ALU and registered result/flags back out.
interface alu_32bit_unit_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       opcode;
    logic             carry_in;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             sign_flag;
    logic             carry_flag;
    logic             overflow_flag;

    modport master (
        output a, b, opcode, carry_in,
        input  result, zero_flag, sign_flag, carry_flag, overflow_flag
    );

    modport slave (
        input  a, b, opcode, carry_in,
        output result, zero_flag, sign_flag, carry_flag, overflow_flag
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator; out_bit is the last bit shifted out (shifts) or the
// bit that wrapped into the far end (rotates), and is 0 for a zero shift amount.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]         value,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  shift_mode_e              mode,
    output logic [WIDTH-1:0]         shifted,
    output logic                     out_bit
);
    logic [2*WIDTH-1:0] wide_l;
    logic [2*WIDTH-1:0] wide_r;

    // Double-width shifts keep the bits that fall off one end, which gives both rotate and carry.
    assign wide_l = {{WIDTH{1'b0}}, value} << amount;
    assign wide_r = {value, {WIDTH{1'b0}}} >> amount;

    always_comb begin
        shifted = '0;
        out_bit = 1'b0;
        case (mode)
            SH_SHL: begin
                shifted = wide_l[WIDTH-1:0];
                out_bit = wide_l[WIDTH];
            end
            SH_SHR: begin
                shifted = wide_r[2*WIDTH-1:WIDTH];
                out_bit = wide_r[WIDTH-1];
            end
            SH_ROL: begin
                shifted = wide_l[WIDTH-1:0] | wide_l[2*WIDTH-1:WIDTH];
                out_bit = (amount != '0) & shifted[0];
            end
            SH_ROR: begin
                shifted = wide_r[2*WIDTH-1:WIDTH] | wide_r[WIDTH-1:0];
                out_bit = (amount != '0) & shifted[WIDTH-1];
            end
            default: begin
                shifted = '0;
                out_bit = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_32bit_unit.sv
// Registered integer ALU: opcode decode feeds one result/flag register bank with async reset.
// Optional ADC/SBB opcodes are compiled in when ALU_CARRY_OPS_EN is defined.
module alu_32bit_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_32bit_unit_if.slave   alu_bus
);
    localparam int unsigned   SHW = $clog2(WIDTH);
    localparam int unsigned   MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Top bit of the result is the borrow: set when the unsigned difference goes negative.
    function automatic logic [WIDTH:0] sub_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic bi);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    endfunction

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    shift_mode_e             sh_mode;
    logic [WIDTH-1:0]        sh_value;
    logic                    sh_out;
    logic [WIDTH:0]          sum_w;
    logic [WIDTH:0]          diff_w;
    logic [WIDTH-1:0]        flag_src;
    logic                    op_valid;
    logic                    use_diff;
    logic                    carry_nxt;
    logic                    ovf_nxt;
    logic [WIDTH-1:0]        res_nxt;
    logic [NUM_FLAGS-1:0]    flg_nxt;
    logic [WIDTH-1:0]        res_p0;
    logic [NUM_FLAGS-1:0]    flg_p0;

    assign a_s = alu_bus.a;
    assign b_s = alu_bus.b;

    always_comb begin
        sh_mode = SH_SHL;
        case (alu_bus.opcode)
            OP_SHR:  sh_mode = SH_SHR;
            OP_ROL:  sh_mode = SH_ROL;
            OP_ROR:  sh_mode = SH_ROR;
            default: sh_mode = SH_SHL;
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value   (alu_bus.a),
        .amount  (alu_bus.b[SHW-1:0]),
        .mode    (sh_mode),
        .shifted (sh_value),
        .out_bit (sh_out)
    );

    // Stage 0: combinational decode of the current operands into next result and flags.
    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        op_valid  = 1'b1;
        use_diff  = 1'b0;
        sum_w     = '0;
        diff_w    = '0;
        case (alu_bus.opcode)
            OP_ADD: begin
                sum_w     = add_carry(alu_bus.a, alu_bus.b, 1'b0);
                res_nxt   = sum_w[WIDTH-1:0];
                carry_nxt = sum_w[WIDTH];
                ovf_nxt   = add_ovf(alu_bus.a, alu_bus.b, res_nxt);
            end
            OP_SUB: begin
                diff_w    = sub_borrow(alu_bus.a, alu_bus.b, 1'b0);
                res_nxt   = diff_w[WIDTH-1:0];
                carry_nxt = diff_w[WIDTH];
                ovf_nxt   = sub_ovf(alu_bus.a, alu_bus.b, res_nxt);
            end
            OP_AND:    res_nxt = alu_bus.a & alu_bus.b;
            OP_OR:     res_nxt = alu_bus.a | alu_bus.b;
            OP_XOR:    res_nxt = alu_bus.a ^ alu_bus.b;
            OP_NOT:    res_nxt = ~alu_bus.a;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                res_nxt   = sh_value;
                carry_nxt = sh_out;
            end
            OP_CMP: begin
                // Result encodes the relations; flags describe a-b as SUB would.
                diff_w    = sub_borrow(alu_bus.a, alu_bus.b, 1'b0);
                res_nxt   = {{(WIDTH-3){1'b0}}, (a_s < b_s), (alu_bus.a < alu_bus.b), (alu_bus.a == alu_bus.b)};
                carry_nxt = diff_w[WIDTH];
                ovf_nxt   = sub_ovf(alu_bus.a, alu_bus.b, diff_w[WIDTH-1:0]);
                use_diff  = 1'b1;
            end
            OP_INC: begin
                sum_w     = add_carry(alu_bus.a, ONE, 1'b0);
                res_nxt   = sum_w[WIDTH-1:0];
                carry_nxt = sum_w[WIDTH];
                ovf_nxt   = add_ovf(alu_bus.a, ONE, res_nxt);
            end
            OP_DEC: begin
                diff_w    = sub_borrow(alu_bus.a, ONE, 1'b0);
                res_nxt   = diff_w[WIDTH-1:0];
                carry_nxt = diff_w[WIDTH];
                ovf_nxt   = sub_ovf(alu_bus.a, ONE, res_nxt);
            end
            OP_PASS_A: res_nxt = alu_bus.a;
            OP_PASS_B: res_nxt = alu_bus.b;
            OP_NAND:   res_nxt = ~(alu_bus.a & alu_bus.b);
            OP_NOR:    res_nxt = ~(alu_bus.a | alu_bus.b);
            OP_XNOR:   res_nxt = ~(alu_bus.a ^ alu_bus.b);
            OP_CLR:    res_nxt = '0;
            OP_SET:    res_nxt = '1;
`ifdef ALU_CARRY_OPS_EN
            OP_ADC: begin
                sum_w     = add_carry(alu_bus.a, alu_bus.b, alu_bus.carry_in);
                res_nxt   = sum_w[WIDTH-1:0];
                carry_nxt = sum_w[WIDTH];
                ovf_nxt   = add_ovf(alu_bus.a, alu_bus.b, res_nxt);
            end
            OP_SBB: begin
                diff_w    = sub_borrow(alu_bus.a, alu_bus.b, alu_bus.carry_in);
                res_nxt   = diff_w[WIDTH-1:0];
                carry_nxt = diff_w[WIDTH];
                ovf_nxt   = sub_ovf(alu_bus.a, alu_bus.b, res_nxt);
            end
`endif
            default:   op_valid = 1'b0;
        endcase
    end

    // Undefined opcodes leave res_nxt at zero but must still report Z=0.
    always_comb begin
        flag_src         = use_diff ? diff_w[WIDTH-1:0] : res_nxt;
        flg_nxt          = '0;
        flg_nxt[FLAG_Z]  = op_valid & (flag_src == '0);
        flg_nxt[FLAG_S]  = op_valid & flag_src[MSB];
        flg_nxt[FLAG_C]  = carry_nxt;
        flg_nxt[FLAG_V]  = ovf_nxt;
    end

    // Stage 0 -> output register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p0 <= '0;
            flg_p0 <= '0;
        end else begin
            res_p0 <= res_nxt;
            flg_p0 <= flg_nxt;
        end
    end

    assign alu_bus.result        = res_p0;
    assign alu_bus.zero_flag     = flg_p0[FLAG_Z];
    assign alu_bus.sign_flag     = flg_p0[FLAG_S];
    assign alu_bus.carry_flag    = flg_p0[FLAG_C];
    assign alu_bus.overflow_flag = flg_p0[FLAG_V];
endmodule

// File: tb/tb_alu_32bit_unit.sv
// Self-checking bench for alu_32bit_unit: directed opcode table, boundaries, reset and random traffic.
module tb_alu_32bit_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;

    alu_32bit_unit_if bus_if ();

    alu_32bit_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_bus (bus_if)
    );

    always #5 clk = ~clk;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic bit out_of_range(input longint x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    // Reference model: flags packed as {Z, S, C, V}.
    function automatic void ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic ci, output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint unsigned uci = {63'b0, ci};
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sci = longint'(uci);
        int sh = int'(b[4:0]);
        bit known = 1'b1;
        bit use_diff = 1'b0;
        logic [31:0] d = '0;
        logic c = 1'b0;
        logic v = 1'b0;
        longint unsigned wide;
        r = '0;
        case (op)
            6'h00: begin wide = ua + ub; r = wide[31:0]; c = (wide >> 32) != 0; v = out_of_range(sa + sb); end
            6'h01: begin r = a - b; c = ua < ub; v = out_of_range(sa - sb); end
            6'h02: r = a & b;
            6'h03: r = a | b;
            6'h04: r = a ^ b;
            6'h05: r = ~a;
            6'h07: begin r = a << sh; c = (sh != 0) && ((((ua << sh) >> 32) & 1) != 0); end
            6'h08: begin r = a >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            6'h09: begin r = a; for (int i = 0; i < sh; i++) r = {r[30:0], r[31]}; c = (sh != 0) && r[0]; end
            6'h0A: begin r = a; for (int i = 0; i < sh; i++) r = {r[0], r[31:1]}; c = (sh != 0) && r[31]; end
            6'h0B: begin
                r = {29'b0, sa < sb, ua < ub, a == b};
                d = a - b; use_diff = 1'b1; c = ua < ub; v = out_of_range(sa - sb);
            end
            6'h0C: begin wide = ua + 1; r = wide[31:0]; c = (wide >> 32) != 0; v = out_of_range(sa + 1); end
            6'h0D: begin r = a - 32'd1; c = ua < 1; v = out_of_range(sa - 1); end
            6'h0E: r = a;
            6'h0F: r = b;
            6'h10: r = ~(a & b);
            6'h11: r = ~(a | b);
            6'h12: r = ~(a ^ b);
            6'h13: r = '0;
            6'h14: r = '1;
`ifdef ALU_CARRY_OPS_EN
            6'h06: begin wide = ua + ub + uci; r = wide[31:0]; c = (wide >> 32) != 0; v = out_of_range(sa + sb + sci); end
            6'h15: begin r = a - b - {31'b0, ci}; c = ua < (ub + uci); v = out_of_range(sa - sb - sci); end
`endif
            default: known = 1'b0;
        endcase
        if (known) f = {use_diff ? (d == 0) : (r == 0), use_diff ? d[31] : r[31], c, v};
        else begin r = '0; f = 4'b0000; end
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus_if.zero_flag, bus_if.sign_flag, bus_if.carry_flag, bus_if.overflow_flag};
    endfunction

    task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci);
        @(negedge clk);
        bus_if.opcode = op; bus_if.a = a; bus_if.b = b; bus_if.carry_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_if.opcode = 6'h00; bus_if.a = 32'd10; bus_if.b = 32'd5; bus_if.carry_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.result !== 32'd0 || dut_flags() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_initial result=%h flags=%b expected=0 flags=0000", bus_if.result, dut_flags());
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.result !== 32'd15) begin
            failures++;
            $display("FAIL reset_release result=%h expected=%h", bus_if.result, 32'd15);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.result !== 32'd0 || dut_flags() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async result=%h flags=%b expected=0 flags=0000", bus_if.result, dut_flags());
        end
        @(posedge clk); #1;
        checks++;
        if (bus_if.result !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold result=%h expected=0", bus_if.result);
        end
        @(negedge clk);
        bus_if.opcode = 6'h01;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.result !== 32'd5) begin
            failures++;
            $display("FAIL reset_resume result=%h expected=%h", bus_if.result, 32'd5);
        end
    endtask

    task automatic test_opcode_table();
        logic [5:0]  ops  [21] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h3F};
        logic [31:0] exp_r[21] = '{32'd15, 32'd5, 32'd0, 32'd15, 32'd15, 32'hFFFFFFF5, 32'd320, 32'd0, 32'd320,
                                   32'h50000000, 32'd0, 32'd11, 32'd9, 32'd10, 32'd5, 32'hFFFFFFFF,
                                   32'hFFFFFFF0, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [3:0]  exp_f[21] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
                                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                                   4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0000};
        for (int i = 0; i < 21; i++) begin
            step(ops[i], 32'd10, 32'd5, 1'b0);
            checks++;
            if (bus_if.result !== exp_r[i]) begin
                failures++;
                $display("FAIL table_result op=%02h result=%h expected=%h", ops[i], bus_if.result, exp_r[i]);
            end
            checks++;
            if (dut_flags() !== exp_f[i]) begin
                failures++;
                $display("FAIL table_flags op=%02h flags=%b expected=%b", ops[i], dut_flags(), exp_f[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [5:0]  ops  [7] = '{6'h00, 6'h00, 6'h01, 6'h0B, 6'h09, 6'h07, 6'h0A};
        logic [31:0] in_a [7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd5, 32'h12345678, 32'h80000001, 32'd1};
        logic [31:0] in_b [7] = '{32'd1, 32'd1, 32'd1, 32'd10, 32'd0, 32'd1, 32'd1};
        logic [31:0] exp_r[7] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd6, 32'h12345678, 32'd2, 32'h80000000};
        logic [3:0]  exp_f[7] = '{4'b0101, 4'b1010, 4'b0110, 4'b0110, 4'b0000, 4'b0010, 4'b0110};
        for (int i = 0; i < 7; i++) begin
            step(ops[i], in_a[i], in_b[i], 1'b1);
            checks++;
            if (bus_if.result !== exp_r[i] || dut_flags() !== exp_f[i]) begin
                failures++;
                $display("FAIL boundary_%0d op=%02h result=%h flags=%b expected=%h flags=%b",
                         i, ops[i], bus_if.result, dut_flags(), exp_r[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_carry_ops();
`ifdef ALU_CARRY_OPS_EN
        logic [5:0]  ops  [3] = '{6'h06, 6'h15, 6'h06};
        logic [31:0] in_a [3] = '{32'd10, 32'd10, 32'hFFFFFFFF};
        logic [31:0] in_b [3] = '{32'd5, 32'd5, 32'd0};
        logic [31:0] exp_r[3] = '{32'd16, 32'd4, 32'd0};
        logic [3:0]  exp_f[3] = '{4'b0000, 4'b0000, 4'b1010};
`else
        logic [5:0]  ops  [3] = '{6'h06, 6'h15, 6'h06};
        logic [31:0] in_a [3] = '{32'd10, 32'd10, 32'hFFFFFFFF};
        logic [31:0] in_b [3] = '{32'd5, 32'd5, 32'd0};
        logic [31:0] exp_r[3] = '{32'd0, 32'd0, 32'd0};
        logic [3:0]  exp_f[3] = '{4'b0000, 4'b0000, 4'b0000};
`endif
        for (int i = 0; i < 3; i++) begin
            step(ops[i], in_a[i], in_b[i], 1'b1);
            checks++;
            if (bus_if.result !== exp_r[i] || dut_flags() !== exp_f[i]) begin
                failures++;
                $display("FAIL carry_op_%0d op=%02h result=%h flags=%b expected=%h flags=%b",
                         i, ops[i], bus_if.result, dut_flags(), exp_r[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(22, 63)) : 6'($urandom_range(0, 21));
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            if ($urandom_range(0, 9) == 0) a = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) b = a;
            ci = 1'($urandom_range(0, 1));
            ref_model(op, a, b, ci, exp_r, exp_f);
            step(op, a, b, ci);
            checks++;
            if (bus_if.result !== exp_r || dut_flags() !== exp_f) begin
                failures++;
                $display("FAIL random op=%02h a=%h b=%h ci=%b result=%h flags=%b expected=%h flags=%b",
                         op, a, b, ci, bus_if.result, dut_flags(), exp_r, exp_f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_opcode_table();
        test_boundaries();
        test_carry_ops();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
